// File: rtl/zeroriscy_csr_access_master.sv
// rtl/zeroriscy_csr_access_master.sv - CSR port initiator: serialises bus commands and bursts onto the CSR register-file port
module zeroriscy_csr_access_master #(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [11:0]      cmd_addr_i,
    input  logic [1:0]       cmd_op_i,
    input  logic [31:0]      cmd_wdata_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             abort_i,
    input  logic             core_busy_i,
    output logic             csr_access_o,
    output logic [11:0]      csr_addr_o,
    output logic [31:0]      csr_wdata_o,
    output logic [1:0]       csr_op_o,
    input  logic [31:0]      csr_rdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [11:0]      rsp_addr_o,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_last_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [11:0]      addr_q;
    logic [1:0]       op_q;
    logic [31:0]      wdata_q;
    logic [LEN_W-1:0] rem_q;
    logic [11:0]      rsp_addr_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_last_q;
    logic             do_access;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over both a pending access and a response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (!core_busy_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (rsp_ready_i) begin
                    state_d = rsp_last_q ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The CSR port is left fully quiet (op NONE, zero address/data) outside an access cycle.
    always_comb begin
        cmd_ready_o  = (state_q == IDLE);
        rsp_valid_o  = (state_q == RESP);
        do_access    = (state_q == ISSUE) && !core_busy_i && !abort_i;
        csr_access_o = do_access;
        csr_addr_o   = do_access ? addr_q  : 12'd0;
        csr_wdata_o  = do_access ? wdata_q : 32'd0;
        csr_op_o     = do_access ? op_q    : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= 12'd0;
            op_q        <= 2'd0;
            wdata_q     <= 32'd0;
            rem_q       <= '0;
            rsp_addr_q  <= 12'd0;
            rsp_rdata_q <= 32'd0;
            rsp_last_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && cmd_valid_i) begin
                addr_q  <= cmd_addr_i;
                op_q    <= cmd_op_i;
                wdata_q <= cmd_wdata_i;
                rem_q   <= cmd_len_i;
            end
            if (do_access) begin
                rsp_addr_q  <= addr_q;
                rsp_rdata_q <= csr_rdata_i;
                rsp_last_q  <= (rem_q == '0);
            end
            // rsp_last_q low guarantees rem_q is non-zero, so the decrement cannot wrap.
            if ((state_q == RESP) && rsp_ready_i && !abort_i && !rsp_last_q) begin
                addr_q <= addr_q + 12'd1;
                rem_q  <= rem_q - LEN_W'(1);
            end
        end
    end

    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_zeroriscy_csr_access_master.sv
// tb/tb_zeroriscy_csr_access_master.sv - scoreboard bench with CSR responder and reference model
module tb_zeroriscy_csr_access_master;

    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [11:0]      cmd_addr;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_wdata;
    logic [LEN_W-1:0] cmd_len;
    logic             abort;
    logic             core_busy;
    logic             core_busy_dir;
    logic             core_busy_rnd;
    logic             csr_access;
    logic [11:0]      csr_addr;
    logic [31:0]      csr_wdata;
    logic [1:0]       csr_op;
    logic [31:0]      csr_rdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [11:0]      rsp_addr;
    logic [31:0]      rsp_rdata;
    logic             rsp_last;

    zeroriscy_csr_access_master #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_op_i     (cmd_op),
        .cmd_wdata_i  (cmd_wdata),
        .cmd_len_i    (cmd_len),
        .abort_i      (abort),
        .core_busy_i  (core_busy),
        .csr_access_o (csr_access),
        .csr_addr_o   (csr_addr),
        .csr_wdata_o  (csr_wdata),
        .csr_op_o     (csr_op),
        .csr_rdata_i  (csr_rdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_addr_o   (rsp_addr),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_last_o   (rsp_last)
    );

    always #5 clk = ~clk;

    assign core_busy = core_busy_dir | core_busy_rnd;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rmem [0:4095];
    logic [31:0] mmem [0:4095];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          acc_cnt  = 0;
    int          rdy_mode = 0;
    bit          busy_rand = 1'b0;

    // mstatus.MPP reads back as machine mode regardless of what is written.
    function automatic logic [31:0] csr_apply(input logic [11:0] a, input logic [1:0] op,
                                              input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] v;
        case (op)
            2'd1:    v = wd;
            2'd2:    v = old | wd;
            2'd3:    v = old & ~wd;
            default: v = old;
        endcase
        if (a == 12'h300) v = v | 32'h0000_1800;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    assign csr_rdata = rmem[csr_addr];

    // Responder: old value visible during the access cycle, new value after the edge.
    initial begin
        bit          pw;
        logic [11:0] pa;
        logic [31:0] pv;
        pw = 1'b0;
        pa = 12'd0;
        pv = 32'd0;
        for (int i = 0; i < 4096; i++) rmem[i] = $urandom;
        rmem[12'h341] = 32'h0000_1234;
        rmem[12'h300] = 32'h0000_1800;
        forever begin
            @(negedge clk);
            pw = csr_access && (csr_op != 2'd0);
            pa = csr_addr;
            pv = csr_apply(csr_addr, csr_op, rmem[csr_addr], csr_wdata);
            @(posedge clk);
            if (pw) rmem[pa] <= pv;
        end
    end

    initial begin
        int bp_cnt;
        bp_cnt = 0;
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom % 2);
                2: begin
                    if (rsp_valid && bp_cnt == 3) begin
                        rsp_ready = 1'b1;
                        bp_cnt = 0;
                    end else if (rsp_valid) begin
                        rsp_ready = 1'b0;
                        bp_cnt++;
                    end else begin
                        rsp_ready = 1'b0;
                    end
                end
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    initial begin
        core_busy_rnd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core_busy_rnd = busy_rand ? ($urandom % 3 == 0) : 1'b0;
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on each response handshake.
    initial begin
        bit          pend;
        bit          prev_abort;
        logic [11:0] s_addr;
        logic [31:0] s_data;
        logic        s_last;
        exp_t        e;
        pend = 1'b0;
        prev_abort = 1'b0;
        s_addr = 12'd0;
        s_data = 32'd0;
        s_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (csr_access) begin
                    acc_cnt++;
                    chk("access_while_busy", 32'(core_busy), 32'd0);
                end else begin
                    chk("op_none_when_idle", 32'(csr_op), 32'd0);
                end
                if (pend && !prev_abort) begin
                    chk("valid_held", 32'(rsp_valid), 32'd1);
                    chk("addr_stable", 32'(rsp_addr), 32'(s_addr));
                    chk("data_stable", rsp_rdata, s_data);
                    chk("last_stable", 32'(rsp_last), 32'(s_last));
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 32'(rsp_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_addr", 32'(rsp_addr), 32'(e.addr));
                        chk("rsp_rdata", rsp_rdata, e.data);
                        chk("rsp_last", 32'(rsp_last), 32'(e.last));
                    end
                end
                pend = rsp_valid && !rsp_ready;
                s_addr = rsp_addr;
                s_data = rsp_rdata;
                s_last = rsp_last;
                prev_abort = abort;
            end
        end
    end

    task automatic model_cmd(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                             input int len);
        logic [11:0] ad;
        exp_t        e;
        for (int i = 0; i <= len; i++) begin
            ad = a + 12'(i);
            e.addr = ad;
            e.data = mmem[ad];
            e.last = (i == len);
            exp_q.push_back(e);
            if (op != 2'd0) mmem[ad] = csr_apply(ad, op, mmem[ad], wd);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                         input int len);
        int b;
        b = 0;
        cmd_addr  = a;
        cmd_op    = op;
        cmd_wdata = wd;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && b < 1000) begin
            @(negedge clk);
            b++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 32'd0, 32'd1);
        end else begin
            model_cmd(a, op, wd, len);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && b < 3000) begin
            @(negedge clk);
            b++;
        end
        chk("done_timeout", 32'(b < 3000), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_valid();
        int b;
        b = 0;
        while (!rsp_valid && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_csr_access"}, 32'(csr_access), 32'd0);
        chk({tag, "_csr_op"}, 32'(csr_op), 32'd0);
        chk({tag, "_csr_addr"}, 32'(csr_addr), 32'd0);
        chk({tag, "_csr_wdata"}, csr_wdata, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_addr"}, 32'(rsp_addr), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_last"}, 32'(rsp_last), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        core_busy_dir = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int          a0;
        logic [11:0] ra;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = 12'd0;
        cmd_op = 2'd0;
        cmd_wdata = 32'd0;
        cmd_len = '0;
        abort = 1'b0;
        core_busy_dir = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        for (int i = 0; i < 4096; i++) mmem[i] = rmem[i];
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read: access one cycle after acceptance, response the cycle after that.
        issue(12'h341, 2'd0, 32'd0, 0);
        @(negedge clk);
        chk("t1_access_cycle", 32'(csr_access), 32'd1);
        chk("t1_access_addr", 32'(csr_addr), 32'h341);
        chk("t1_access_op", 32'(csr_op), 32'd0);
        @(negedge clk);
        chk("t1_rsp_valid_latency", 32'(rsp_valid), 32'd1);
        wait_done();

        issue(12'h300, 2'd1, 32'h8, 0);
        wait_done();
        issue(12'h300, 2'd0, 32'd0, 0);
        wait_done();
        issue(12'h300, 2'd2, 32'h80, 0);
        wait_done();

        rdy_mode = 2;
        a0 = acc_cnt;
        issue(12'h780, 2'd0, 32'd0, 3);
        wait_done();
        chk("t3_burst_strobes", 32'(acc_cnt - a0), 32'd4);
        rdy_mode = 0;

        core_busy_dir = 1'b1;
        issue(12'h342, 2'd0, 32'd0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_no_access_busy", 32'(csr_access), 32'd0);
            @(posedge clk);
            #1;
            if (i == 4) core_busy_dir = 1'b0;
        end
        @(negedge clk);
        chk("t4_access_after_busy", 32'(csr_access), 32'd1);
        wait_done();

        a0 = acc_cnt;
        issue(12'hFFF, 2'd2, $urandom, 1);
        wait_done();
        chk("t5_wrap_strobes", 32'(acc_cnt - a0), 32'd2);

        rdy_mode = 3;
        a0 = acc_cnt;
        issue(12'h100, 2'd0, 32'd0, 3);
        wait_rsp_valid();
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk);
        chk("t5_abort_strobes", 32'(acc_cnt - a0), 32'd1);
        chk("t5_abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t5_abort_rsp_valid", 32'(rsp_valid), 32'd0);
        rdy_mode = 0;
        @(posedge clk);
        #1;

        // Abort arriving in the very cycle the access would have been driven.
        a0 = acc_cnt;
        issue(12'h110, 2'd1, 32'hDEAD_BEEF, 0);
        abort = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4096; i++) mmem[i] = rmem[i];
        @(negedge clk);
        chk("t5_abort_issue_no_access", 32'(csr_access), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_abort_issue_strobes", 32'(acc_cnt - a0), 32'd0);
        chk("t5_abort_issue_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        core_busy_dir = 1'b1;
        issue(12'h200, 2'd0, 32'd0, 2);
        @(posedge clk);
        #1;
        pulse_reset();
        check_reset_outputs("rst_issue");
        @(posedge clk);
        #1;

        rdy_mode = 3;
        issue(12'h204, 2'd0, 32'd0, 2);
        wait_rsp_valid();
        @(posedge clk);
        #1;
        pulse_reset();
        check_reset_outputs("rst_resp");
        rdy_mode = 0;
        @(posedge clk);
        #1;
        issue(12'h341, 2'd0, 32'd0, 1);
        wait_done();

        rdy_mode = 1;
        busy_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            ra = ($urandom % 4 == 0) ? 12'(12'hFF0 + ($urandom % 16)) : 12'($urandom);
            issue(ra, 2'($urandom % 4), $urandom,
                  ($urandom % 5 == 0) ? int'($urandom % 32) : int'($urandom % 4));
            wait_done();
        end
        busy_rand = 1'b0;
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
